// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the external memory bus master: FSM encoding,
// idle strobe levels and counter widths.
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALE     = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic IDLE_NME  = 1'b1;
  localparam logic IDLE_NALE = 1'b1;
  localparam logic IDLE_NOE  = 1'b1;
  localparam logic IDLE_RNW  = 1'b1;
  localparam logic IDLE_ENB  = 1'b1;

  localparam int WCNT_W = 4;
  localparam int IDX_W  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: first requester strictly after
// the pointer, wrapping modulo NCORES.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic [NCORES-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic [7:0]       req_pad_s;
  logic [3:0]       sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    req_pad_s = 8'd0;
    req_pad_s[NCORES-1:0] = req;
    valid  = 1'b0;
    idx    = 3'd0;
    sum_s  = 4'd0;
    cand_s = 3'd0;
    for (int k = NCORES; k >= 1; k--) begin
      sum_s = {1'b0, ptr} + 4'(k);
      if (sum_s >= 4'(NCORES)) begin
        cand_s = 3'(sum_s - 4'(NCORES));
      end else begin
        cand_s = 3'(sum_s);
      end
      if (req_pad_s[cand_s]) begin
        valid = 1'b1;
        idx   = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared external-memory bus master: round-robin arbitration of NCORES
// request ports onto one multiplexed address/data bus with wait states.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NCORES      = 4,
  parameter int DW          = 64,
  parameter int AW          = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NCORES-1:0]    Req,
  input  logic [NCORES-1:0]    ReqRnW,
  input  logic [NCORES*AW-1:0] ReqAddr,
  input  logic [NCORES*DW-1:0] ReqWData,
  output logic [NCORES-1:0]    Ack,
  output logic [DW-1:0]        RData,
  output logic [2:0]           GrantId,
  output logic                 Busy,
  output logic [DW-1:0]        Data_out,
  input  logic [DW-1:0]        Data_in,
  output logic                 ENB,
  output logic                 nME,
  output logic                 nALE,
  output logic                 RnW,
  output logic                 nOE
);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, grant_q, grant_d;
  logic              rnw_lat_q, rnw_lat_d;
  logic [AW-1:0]     addr_lat_q, addr_lat_d;
  logic [DW-1:0]     wdata_lat_q, wdata_lat_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [NCORES-1:0] ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d, dout_q, dout_d;
  logic              busy_q, busy_d, enb_q, enb_d, nme_q, nme_d;
  logic              nale_q, nale_d, rnw_q, rnw_d, noe_q, noe_d;

  logic              win_valid_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [AW-1:0]     addr_sel_s;
  logic [DW-1:0]     wdata_sel_s;
  logic              rnw_sel_s;

  rr_arbiter #(.NCORES(NCORES)) u_rr (
    .req   (Req),
    .ptr   (ptr_q),
    .valid (win_valid_s),
    .idx   (win_idx_s)
  );

  // Pick the winning core's request fields.
  always_comb begin
    addr_sel_s  = '0;
    wdata_sel_s = '0;
    rnw_sel_s   = 1'b1;
    for (int i = 0; i < NCORES; i++) begin
      if (win_idx_s == 3'(i)) begin
        addr_sel_s  = ReqAddr[i*AW +: AW];
        wdata_sel_s = ReqWData[i*DW +: DW];
        rnw_sel_s   = ReqRnW[i];
      end else begin
        rnw_sel_s = rnw_sel_s;
      end
    end
  end

  // Sequencing; read data is captured on the edge leaving the last ACCESS cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    rnw_lat_d   = rnw_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    wcnt_d      = wcnt_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_d     = ST_ALE;
          grant_d     = win_idx_s;
          ptr_d       = win_idx_s;
          addr_lat_d  = addr_sel_s;
          wdata_lat_d = wdata_sel_s;
          rnw_lat_d   = rnw_sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALE: begin
        state_d = ST_ACCESS;
        wcnt_d  = WCNT_W'(WAIT_STATES);
      end
      ST_ACCESS: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_RECOVER;
          if (rnw_lat_q) begin
            rdata_d = Data_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so every pin is a flop.
  always_comb begin
    nme_d  = IDLE_NME;
    nale_d = IDLE_NALE;
    noe_d  = IDLE_NOE;
    rnw_d  = IDLE_RNW;
    enb_d  = IDLE_ENB;
    dout_d = '0;
    ack_d  = '0;
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
    case (state_d)
      ST_ALE: begin
        nme_d  = 1'b0;
        nale_d = 1'b0;
        rnw_d  = rnw_lat_d;
        enb_d  = 1'b0;
        dout_d = DW'(addr_lat_d);
      end
      ST_ACCESS: begin
        nme_d = 1'b0;
        if (rnw_lat_d) begin
          noe_d = 1'b0;
        end else begin
          rnw_d  = 1'b0;
          enb_d  = 1'b0;
          dout_d = wdata_lat_d;
        end
      end
      ST_RECOVER: begin
        for (int i = 0; i < NCORES; i++) begin
          ack_d[i] = (grant_d == 3'(i));
        end
      end
      ST_IDLE: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'(NCORES - 1);
      grant_q     <= 3'd0;
      rnw_lat_q   <= 1'b1;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
      wcnt_q      <= 4'd0;
      ack_q       <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      busy_q      <= 1'b0;
      enb_q       <= IDLE_ENB;
      nme_q       <= IDLE_NME;
      nale_q      <= IDLE_NALE;
      rnw_q       <= IDLE_RNW;
      noe_q       <= IDLE_NOE;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      rnw_lat_q   <= rnw_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      wcnt_q      <= wcnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      enb_q       <= enb_d;
      nme_q       <= nme_d;
      nale_q      <= nale_d;
      rnw_q       <= rnw_d;
      noe_q       <= noe_d;
    end
  end

  assign Ack      = ack_q;
  assign RData    = rdata_q;
  assign GrantId  = grant_q;
  assign Busy     = busy_q;
  assign Data_out = dout_q;
  assign ENB      = enb_q;
  assign nME      = nme_q;
  assign nALE     = nale_q;
  assign RnW      = rnw_q;
  assign nOE      = noe_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (WAIT_STATES 0 and 1) share
// stimulus and are compared each cycle against a transaction-timeline model.
module tb_mem_bus_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_rnw;
  logic [N*32-1:0] req_addr;
  logic [N*64-1:0] req_wdata;
  logic [63:0]   data_in;

  logic [N-1:0]  ack_o [2];
  logic [63:0]   rdata_o [2];
  logic [63:0]   dout_o [2];
  logic [2:0]    gid_o [2];
  logic          busy_o [2], enb_o [2], nme_o [2], nale_o [2], rnw_o [2], noe_o [2];

  int checks = 0;
  int failures = 0;

  // Model: per instance (index == wait states), offset of the cycle within the transaction.
  bit          m_act [2];
  int          m_off [2], m_win [2], m_ptr [2], m_gid [2];
  bit          m_rnw [2];
  logic [31:0] m_addr [2];
  logic [63:0] m_wd [2], m_rd [2];

  int gq[$];
  int tq[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NCORES(N), .DW(64), .AW(32), .WAIT_STATES(0)) u_dut_w0 (
    .Clock(clk), .Reset(rst), .Req(req), .ReqRnW(req_rnw), .ReqAddr(req_addr),
    .ReqWData(req_wdata), .Ack(ack_o[0]), .RData(rdata_o[0]), .GrantId(gid_o[0]),
    .Busy(busy_o[0]), .Data_out(dout_o[0]), .Data_in(data_in), .ENB(enb_o[0]),
    .nME(nme_o[0]), .nALE(nale_o[0]), .RnW(rnw_o[0]), .nOE(noe_o[0])
  );

  mem_bus_arbiter #(.NCORES(N), .DW(64), .AW(32), .WAIT_STATES(1)) u_dut_w1 (
    .Clock(clk), .Reset(rst), .Req(req), .ReqRnW(req_rnw), .ReqAddr(req_addr),
    .ReqWData(req_wdata), .Ack(ack_o[1]), .RData(rdata_o[1]), .GrantId(gid_o[1]),
    .Busy(busy_o[1]), .Data_out(dout_o[1]), .Data_in(data_in), .ENB(enb_o[1]),
    .nME(nme_o[1]), .nALE(nale_o[1]), .RnW(rnw_o[1]), .nOE(noe_o[1])
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_act[k] = 1'b0;
    m_off[k] = 0;
    m_win[k] = 0;
    m_ptr[k] = N - 1;
    m_gid[k] = 0;
    m_rd[k]  = 64'd0;
  endtask

  // One clock edge of the model, using the inputs the DUT saw at that edge.
  task automatic model_step(input int k);
    int w;
    bit found;
    int c;
    w = k;
    found = 1'b0;
    if (rst) begin
      model_reset(k);
    end else if (m_act[k]) begin
      if (m_off[k] == 2 + w && m_rnw[k]) m_rd[k] = data_in;
      m_off[k]++;
      if (m_off[k] == 4 + w) m_act[k] = 1'b0;
    end else begin
      for (int j = 1; j <= N; j++) begin
        c = (m_ptr[k] + j) % N;
        if (!found && req[c]) begin
          found     = 1'b1;
          m_win[k]  = c;
          m_ptr[k]  = c;
          m_gid[k]  = c;
          m_rnw[k]  = req_rnw[c];
          m_addr[k] = req_addr[c*32 +: 32];
          m_wd[k]   = req_wdata[c*64 +: 64];
        end
      end
      if (found) begin
        m_act[k] = 1'b1;
        m_off[k] = 1;
      end
    end
  endtask

  task automatic compare(input int k);
    logic e_nme, e_nale, e_noe, e_rnw, e_enb, e_busy;
    logic [N-1:0] e_ack;
    logic [63:0] e_dout;
    int w;
    w = k;
    e_nme = 1'b1; e_nale = 1'b1; e_noe = 1'b1; e_rnw = 1'b1; e_enb = 1'b1;
    e_busy = 1'b0; e_ack = '0; e_dout = 64'd0;
    if (m_act[k]) begin
      e_busy = 1'b1;
      if (m_off[k] == 1) begin
        e_nme = 1'b0; e_nale = 1'b0; e_rnw = m_rnw[k]; e_enb = 1'b0;
        e_dout = {32'd0, m_addr[k]};
      end else if (m_off[k] <= 2 + w) begin
        e_nme = 1'b0;
        if (m_rnw[k]) begin
          e_noe = 1'b0;
        end else begin
          e_rnw = 1'b0; e_enb = 1'b0; e_dout = m_wd[k];
        end
      end else begin
        e_ack = 4'b0001 << m_win[k];
      end
    end
    chk_val($sformatf("w%0d_nME", k), 64'(nme_o[k]), 64'(e_nme));
    chk_val($sformatf("w%0d_nALE", k), 64'(nale_o[k]), 64'(e_nale));
    chk_val($sformatf("w%0d_nOE", k), 64'(noe_o[k]), 64'(e_noe));
    chk_val($sformatf("w%0d_RnW", k), 64'(rnw_o[k]), 64'(e_rnw));
    chk_val($sformatf("w%0d_ENB", k), 64'(enb_o[k]), 64'(e_enb));
    chk_val($sformatf("w%0d_Busy", k), 64'(busy_o[k]), 64'(e_busy));
    chk_val($sformatf("w%0d_Ack", k), 64'(ack_o[k]), 64'(e_ack));
    chk_val($sformatf("w%0d_Data_out", k), dout_o[k], e_dout);
    chk_val($sformatf("w%0d_RData", k), rdata_o[k], m_rd[k]);
    chk_val($sformatf("w%0d_GrantId", k), 64'(gid_o[k]), 64'(m_gid[k]));
    chk_val($sformatf("w%0d_no_contention", k), 64'(enb_o[k] | noe_o[k]), 64'd1);
  endtask

  // Advance one clock: model and compare just after the edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      compare(k);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      compare(k);
    end
    cycle();
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Record grant ids and call indices of WAIT_STATES=1 acks.
  task automatic run_collect(input int n);
    gq.delete();
    tq.delete();
    for (int c = 1; c <= n; c++) begin
      cycle();
      if (ack_o[1] != '0) begin
        gq.push_back(int'(gid_o[1]));
        tq.push_back(c);
      end
    end
  endtask

  task automatic set_core(input int c, input bit rnw, input logic [31:0] a, input logic [63:0] d);
    req_rnw[c] = rnw;
    req_addr[c*32 +: 32] = a;
    req_wdata[c*64 +: 64] = d;
  endtask

  initial begin
    int lat [2];
    int a3;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0; req_rnw = '1; req_addr = '0; req_wdata = '0; data_in = 64'd0;
    @(negedge clk);
    do_reset();

    // Core0 read of 0x1000 with a fixed bus value.
    set_core(0, 1'b1, 32'h1000, 64'd0);
    data_in = 64'hDEADBEEFCAFEF00D;
    req = 4'b0001;
    cycle();
    chk_val("rd_ale_addr", dout_o[1], 64'h1000);
    req = '0;
    cycle();
    chk_val("rd_acc_noe", 64'(noe_o[1]), 64'd0);
    chk_val("rd_acc_enb", 64'(enb_o[1]), 64'd1);
    cycle();
    cycle();
    chk_val("rd_ack", 64'(ack_o[1]), 64'h1);
    chk_val("rd_rdata", rdata_o[1], 64'hDEADBEEFCAFEF00D);
    idle_cycles(3);

    // Core2 write; RData must stay at the previous read value.
    set_core(2, 1'b0, 32'h20, 64'h55AA);
    req = 4'b0100;
    cycle();
    chk_val("wr_ale_addr", dout_o[1], 64'h20);
    req = '0;
    cycle();
    chk_val("wr_acc_rnw", 64'(rnw_o[1]), 64'd0);
    chk_val("wr_acc_enb", 64'(enb_o[1]), 64'd0);
    chk_val("wr_acc_data", dout_o[1], 64'h55AA);
    cycle();
    cycle();
    chk_val("wr_ack", 64'(ack_o[1]), 64'h4);
    chk_val("wr_rdata_kept", rdata_o[1], 64'hDEADBEEFCAFEF00D);
    idle_cycles(3);

    // All four requests held from reset: order 0,1,2,3,0 at 5-cycle spacing.
    do_reset();
    req = 4'b1111;
    run_collect(26);
    chk_val("rr_all_count", 64'(gq.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk_val($sformatf("rr_all_order%0d", i), 64'(gq[i]), 64'(exp_order[i]));
      if (i > 0) chk_val($sformatf("rr_all_span%0d", i), 64'(tq[i] - tq[i-1]), 64'd5);
    end
    idle_cycles(8);

    // After core2 is served, core3 beats core1.
    req = 4'b0100;
    cycle();
    idle_cycles(6);
    req = 4'b1010;
    run_collect(12);
    req = '0;
    chk_val("rr_13_count", 64'(gq.size() >= 2), 64'd1);
    if (gq.size() >= 2) begin
      chk_val("rr_13_first", 64'(gq[0]), 64'd3);
      chk_val("rr_13_second", 64'(gq[1]), 64'd1);
    end
    idle_cycles(8);

    // Asynchronous reset during a read ACCESS, core0 pending.
    set_core(1, 1'b1, 32'hABC0, 64'd0);
    req = 4'b0010;
    cycle();
    cycle();
    req = 4'b0011;
    do_reset();
    run_collect(6);
    chk_val("rst_first_count", 64'(gq.size() >= 1), 64'd1);
    if (gq.size() >= 1) chk_val("rst_first_core0", 64'(gq[0]), 64'd0);
    idle_cycles(8);

    // Latency per wait-state setting; core3 pulsed while busy is never served.
    set_core(0, 1'b1, 32'h44, 64'd0);
    lat[0] = 0; lat[1] = 0; a3 = 0;
    for (int c = 1; c <= 12; c++) begin
      req = (c == 1) ? 4'b0001 : (c == 2) ? 4'b1000 : 4'b0000;
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (ack_o[k][0] && lat[k] == 0) lat[k] = c;
        if (ack_o[k][3]) a3++;
      end
    end
    chk_val("lat_w0", 64'(lat[0]), 64'd3);
    chk_val("lat_w1", 64'(lat[1]), 64'd4);
    chk_val("pulse_never_acked", 64'(a3), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) req[c] = ~req[c];
        set_core(c, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
      end
      data_in = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised shared external-memory bus master. NCORES core-side request ports are multiplexed onto one multiplexed address/data bus using the nME/nALE/RnW/nOE strobe protocol.
- Fair round-robin arbitration between cores.
- Programmable wait states on each access.
- Sits between the cpu_core instances and the top-level tri-state Data pad logic; ENB==0 means the pad drives Data_out.

Parameters:
- NCORES, 4, number of requesting cores (2..8).
- DW, 64, external data bus width.
- AW, 32, address width; the address is zero-extended onto Data_out during the ALE phase.
- WAIT_STATES, 1, extra ACCESS cycles beyond the first (0..15).

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  NCORES  per-core request; hold high until Ack.
- ReqRnW  input  NCORES  per-core direction, 1=read, 0=write.
- ReqAddr  input  NCORES*AW  per-core address; core i occupies slice [i*AW +: AW].
- ReqWData  input  NCORES*DW  per-core write data, sliced the same way.
- Ack  output  NCORES  one-cycle completion pulse to the granted core.
- RData  output  DW  read data, valid in the Ack cycle; holds until the next read completes.
- GrantId  output  3  index of the current or last granted core.
- Busy  output  1  high in every state except IDLE.
- Data_out  output  DW  address (ALE phase) or write data (write ACCESS).
- Data_in  input  DW  bus read data.
- ENB  output  1  pad output enable, active-low.
- nME  output  1  memory enable, active-low.
- nALE  output  1  address latch enable, active-low.
- RnW  output  1  1=read, 0=write.
- nOE  output  1  memory output enable, active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State=IDLE.
  - nME=nALE=nOE=RnW=ENB=1.
  - Ack=0, Busy=0, Data_out=0, RData=0, GrantId=0.
  - Round-robin pointer = NCORES-1, so core 0 wins first.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - Idle strobes as above.
  - If any Req bit is high at a clock edge, select the winner as the first requesting index searching upward from pointer+1 (mod NCORES).
  - Latch the winner's address, wdata and RnW; set GrantId; pointer := winner; next state ALE.
- ALE (1 cycle): nME=0, nALE=0, RnW=latched, nOE=1, ENB=0, Data_out=zero-extended address.
- ACCESS (WAIT_STATES+1 cycles, down-counter):
  - Common: nME=0, nALE=1.
  - Read: RnW=1, nOE=0, ENB=1.
  - Write: RnW=0, nOE=1, ENB=0, Data_out=latched wdata.
  - Read data: Data_in is captured into RData on the clock edge that ends the last ACCESS cycle.
- RECOVER (1 cycle):
  - nME=nALE=nOE=1, ENB=1; RnW returns to 1.
  - Ack[GrantId]=1; RData is valid for reads.
  - Next state IDLE; no back-to-back bus turnaround without passing through IDLE.
- Latency: Req sampled at edge 0 -> ALE in cycle 1 -> ACCESS in cycles 2..2+WAIT_STATES -> Ack in cycle 3+WAIT_STATES -> IDLE. Each transaction occupies 4+WAIT_STATES cycles.
- Simultaneous requests: resolved by round robin only. A core just served has the lowest priority next time.
- Withdrawn request:
  - Req dropped before grant: the core is not served.
  - Req dropped after grant: ignored; the transaction completes and Ack still pulses.
- Ack and Req in the same cycle: a core may raise Req for a new transaction in the cycle after Ack. Req still high during the Ack cycle is treated as a new request in the following IDLE.
- ENB is never 0 while nOE is 0, so there is no bus contention.
- Only RData is updated on reads; write transactions leave RData unchanged.

Decomposition:
- Package mem_bus_pkg holds:
  - State enum: IDLE, ALE, ACCESS, RECOVER.
  - Idle-strobe constants.
  - Wait-counter width constant: 4 bits.
- Sub-module rr_arbiter(NCORES): combinational winner selection from Req and pointer, outputs a valid flag and an index. The pointer register lives in the parent.

Test Plan:
- Core0 read, Addr=0x1000, WAIT_STATES=1, Data_in=0xDEADBEEFCAFEF00D during ACCESS -> ALE cycle 1 with Data_out=0x1000; nOE=0 and ENB=1 in cycles 2-3; Ack[0] in cycle 4 with RData=0xDEADBEEFCAFEF00D.
- Core2 write, Addr=0x20, WData=0x55AA -> ALE with Data_out=0x20; ACCESS with RnW=0, ENB=0, Data_out=0x55AA, nOE=1; Ack[2] only; RData unchanged.
- All four Req high and held after reset -> grant order 0,1,2,3,0; each transaction spans 5 cycles.
- After core2 served, Req=core1|core3 -> core3 granted first, then core1.
- Reset asserted mid-ACCESS of a read -> strobes and ENB go to 1 immediately (asynchronously); no Ack; after release, a pending core0 request is served first.
- WAIT_STATES=0, single read -> Ack in cycle 3; Req pulsed then dropped while another transaction is in progress -> that core is never acked.
